// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles both requester ports and the adapter-side port of mem_port_arbiter.
// Latency : n/a (wires only).
// Backpressure: adapter stalls the arbiter through mem_req_ready; requesters wait for *_req_ready.
// Modports: slave  - the arbiter (receives requests, drives grants/responses and the adapter request)
//           master - the surroundings (fetch unit, load/store unit and AXI4-Lite adapter)
interface mem_port_arbiter_if;
  // fetch requester
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_rdata;
  // data requester
  logic        d_req_valid;
  logic        d_req_write;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_rdata;
  // adapter side
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  // status
  logic        busy;
  logic        owner;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_rdata,
    input  d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output busy, owner
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_rdata,
    output d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares the single adapter request port between fetch and data; one transaction in flight.
// Latency : grant at t (combinational ready), mem_req_valid at t+1, response passed through same cycle.
// Backpressure: request fields held while mem_req_ready=0; no grants until the response returns.
// Ports   : clk, rst (async, active-high); bus (slave modport) carries fetch/data request+response,
//           adapter request/response, and busy/owner status.
module mem_port_arbiter #(
  parameter int DATA_MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(DATA_MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          owner_q;
  logic          busy_q;
  logic          mem_vld_q;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;

  logic idle_ok;
  logic grant_d;
  logic grant_i;
  logic resp_fire;

  // Grants are combinational, so they are also masked while reset is held.
  always_comb begin
    idle_ok   = (state == IDLE) && !rst;
    // Data wins unless fetch is waiting and data has used up its streak.
    grant_d   = idle_ok && bus.d_req_valid && (!bus.if_req_valid || (streak < STREAK_MAX));
    grant_i   = idle_ok && bus.if_req_valid && !grant_d;
    resp_fire = (state == WAIT_RESP) && bus.mem_resp_valid;
  end

  assign bus.if_req_ready  = grant_i;
  assign bus.d_req_ready   = grant_d;
  assign bus.if_resp_valid = resp_fire && !owner_q;
  assign bus.d_resp_valid  = resp_fire && owner_q;
  assign bus.if_resp_rdata = bus.mem_resp_rdata;
  assign bus.d_resp_rdata  = bus.mem_resp_rdata;

  assign bus.mem_req_valid = mem_vld_q;
  assign bus.mem_req_write = write_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wstrb = wstrb_q;
  assign bus.busy          = busy_q;
  assign bus.owner         = owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      mem_vld_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            state     <= ISSUE;
            busy_q    <= 1'b1;
            mem_vld_q <= 1'b1;
            owner_q   <= grant_d;
            // The streak only grows while fetch is actually being passed over.
            streak    <= (grant_d && bus.if_req_valid) ? streak + SW'(1) : '0;
            if (grant_d) begin
              write_q <= bus.d_req_write;
              addr_q  <= bus.d_req_addr;
              wdata_q <= bus.d_req_wdata;
              wstrb_q <= bus.d_req_wstrb;
            end else begin
              write_q <= 1'b0;
              addr_q  <= bus.if_req_addr;
              wdata_q <= '0;
              wstrb_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            state     <= WAIT_RESP;
            mem_vld_q <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (bus.mem_resp_valid) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          mem_vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter (DATA_MAX_STREAK=4).
// Latency : inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: mem_req_ready / mem_resp_valid driven directly by the scenario tasks.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.DATA_MAX_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.d_req_valid    = 1'b0;
    bus.d_req_write    = 1'b0;
    bus.d_req_addr     = '0;
    bus.d_req_wdata    = '0;
    bus.d_req_wstrb    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    bus.if_req_valid = 1'b1;
    bus.d_req_valid  = 1'b1;
    settle();
    vectors++; if (bus.if_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_if_ready got=%b exp=0", bus.if_req_ready); end
    vectors++; if (bus.d_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_d_ready got=%b exp=0", bus.d_req_ready); end
    vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_valid got=%b exp=0", bus.mem_req_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.owner !== 1'b0) begin miscompares++; $display("FAIL rst_owner got=%b exp=0", bus.owner); end
    vectors++; if (bus.mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got=%h exp=0", bus.mem_req_addr); end
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    // t0: grant
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h0000_0100;
    bus.mem_req_ready = 1'b1;
    settle();
    vectors++; if (bus.if_req_ready !== 1'b1) begin miscompares++; $display("FAIL fetch_grant got=%b exp=1", bus.if_req_ready); end
    vectors++; if (bus.d_req_ready !== 1'b0) begin miscompares++; $display("FAIL fetch_no_dgrant got=%b exp=0", bus.d_req_ready); end
    // t1: issue
    tick();
    bus.if_req_valid = 1'b0;
    settle();
    vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_issue_valid got=%b exp=1", bus.mem_req_valid); end
    vectors++; if (bus.mem_req_addr !== 32'h0000_0100) begin miscompares++; $display("FAIL fetch_issue_addr got=%h exp=00000100", bus.mem_req_addr); end
    vectors++; if (bus.mem_req_write !== 1'b0) begin miscompares++; $display("FAIL fetch_issue_write got=%b exp=0", bus.mem_req_write); end
    vectors++; if (bus.mem_req_wstrb !== 4'h0) begin miscompares++; $display("FAIL fetch_issue_wstrb got=%h exp=0", bus.mem_req_wstrb); end
    vectors++; if ({bus.busy, bus.owner} !== 2'b10) begin miscompares++; $display("FAIL fetch_busy_owner got=%b exp=10", {bus.busy, bus.owner}); end
    // t2: waiting
    tick();
    settle();
    vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_wait_valid got=%b exp=0", bus.mem_req_valid); end
    vectors++; if ({bus.if_resp_valid, bus.d_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL fetch_wait_resp got=%b exp=00", {bus.if_resp_valid, bus.d_resp_valid}); end
    // t3: response
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hDEAD_BEEF;
    settle();
    vectors++; if (bus.if_resp_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_resp_valid got=%b exp=1", bus.if_resp_valid); end
    vectors++; if (bus.if_resp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL fetch_resp_rdata got=%h exp=deadbeef", bus.if_resp_rdata); end
    vectors++; if (bus.d_resp_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_resp_dvalid got=%b exp=0", bus.d_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    vectors++; if ({bus.busy, bus.if_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL fetch_done got=%b exp=00", {bus.busy, bus.if_resp_valid}); end
  endtask

  task automatic test_data_write();
    bus.d_req_valid  = 1'b1;
    bus.d_req_write  = 1'b1;
    bus.d_req_addr   = 32'h0000_2000;
    bus.d_req_wdata  = 32'h1234_5678;
    bus.d_req_wstrb  = 4'hF;
    bus.mem_req_ready = 1'b1;
    settle();
    vectors++; if ({bus.d_req_ready, bus.if_req_ready} !== 2'b10) begin miscompares++; $display("FAIL dw_grant got=%b exp=10", {bus.d_req_ready, bus.if_req_ready}); end
    tick();
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    settle();
    vectors++; if ({bus.mem_req_valid, bus.mem_req_write} !== 2'b11) begin miscompares++; $display("FAIL dw_valid_write got=%b exp=11", {bus.mem_req_valid, bus.mem_req_write}); end
    vectors++; if (bus.mem_req_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL dw_addr got=%h exp=00002000", bus.mem_req_addr); end
    vectors++; if (bus.mem_req_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL dw_wdata got=%h exp=12345678", bus.mem_req_wdata); end
    vectors++; if (bus.mem_req_wstrb !== 4'hF) begin miscompares++; $display("FAIL dw_wstrb got=%h exp=f", bus.mem_req_wstrb); end
    tick();
    bus.mem_resp_valid = 1'b1;
    settle();
    vectors++; if ({bus.d_resp_valid, bus.if_resp_valid} !== 2'b10) begin miscompares++; $display("FAIL dw_resp got=%b exp=10", {bus.d_resp_valid, bus.if_resp_valid}); end
    vectors++; if (bus.owner !== 1'b1) begin miscompares++; $display("FAIL dw_owner got=%b exp=1", bus.owner); end
    tick();
    clear_inputs();
  endtask

  task automatic test_fairness();
    logic exp_d [12];
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h0000_0400;
    bus.d_req_valid   = 1'b1;
    bus.d_req_addr    = 32'h0000_8000;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      settle();
      vectors++;
      if ({bus.d_req_ready, bus.if_req_ready} !== {exp_d[i], ~exp_d[i]}) begin
        miscompares++;
        $display("FAIL fair_grant[%0d] got d,i=%b exp=%b", i, {bus.d_req_ready, bus.if_req_ready}, {exp_d[i], ~exp_d[i]});
      end
      tick();
      settle();
      vectors++; if ({bus.d_req_ready, bus.if_req_ready} !== 2'b00) begin miscompares++; $display("FAIL fair_issue_grant[%0d] got=%b exp=00", i, {bus.d_req_ready, bus.if_req_ready}); end
      vectors++; if (bus.mem_req_addr !== (exp_d[i] ? 32'h0000_8000 : 32'h0000_0400)) begin miscompares++; $display("FAIL fair_addr[%0d] got=%h", i, bus.mem_req_addr); end
      tick();
      if (i == 11) begin
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
      end
      bus.mem_resp_valid = 1'b1;
      settle();
      vectors++; if ({bus.d_req_ready, bus.if_req_ready} !== 2'b00) begin miscompares++; $display("FAIL fair_wait_grant[%0d] got=%b exp=00", i, {bus.d_req_ready, bus.if_req_ready}); end
      vectors++; if ({bus.d_resp_valid, bus.if_resp_valid} !== {exp_d[i], ~exp_d[i]}) begin miscompares++; $display("FAIL fair_resp[%0d] got=%b exp=%b", i, {bus.d_resp_valid, bus.if_resp_valid}, {exp_d[i], ~exp_d[i]}); end
      tick();
      bus.mem_resp_valid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    bus.d_req_valid  = 1'b1;
    bus.d_req_write  = 1'b1;
    bus.d_req_addr   = 32'h0000_3000;
    bus.d_req_wdata  = 32'hA5A5_0001;
    bus.d_req_wstrb  = 4'h3;
    bus.mem_req_ready = 1'b0;
    settle();
    vectors++; if (bus.d_req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_grant got=%b exp=1", bus.d_req_ready); end
    // d_req_valid stays high (with changed fields) the whole time
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.d_req_addr  = 32'h0000_3FF0;
      bus.d_req_wdata = 32'hFFFF_FFFF;
      if (k == 3) bus.mem_req_ready = 1'b1;
      settle();
      vectors++; if ({bus.mem_req_valid, bus.busy, bus.d_req_ready} !== 3'b110) begin miscompares++; $display("FAIL bp_hold[%0d] valid,busy,rdy got=%b exp=110", k, {bus.mem_req_valid, bus.busy, bus.d_req_ready}); end
      vectors++; if ({bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb, bus.mem_req_write} !== {32'h0000_3000, 32'hA5A5_0001, 4'h3, 1'b1}) begin miscompares++; $display("FAIL bp_fields[%0d] addr=%h wdata=%h wstrb=%h", k, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb); end
    end
    tick();
    bus.d_req_valid    = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFE_F00D;
    settle();
    vectors++; if ({bus.mem_req_valid, bus.d_req_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_wait got=%b exp=00", {bus.mem_req_valid, bus.d_req_ready}); end
    vectors++; if ({bus.d_resp_valid, bus.d_resp_rdata} !== {1'b1, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL bp_resp valid=%b rdata=%h exp 1/cafef00d", bus.d_resp_valid, bus.d_resp_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bus.d_req_valid   = 1'b1;
    bus.d_req_write   = 1'b1;
    bus.d_req_addr    = 32'h0000_5000;
    bus.d_req_wdata   = 32'h0BAD_CAFE;
    bus.d_req_wstrb   = 4'hC;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.d_req_valid = 1'b0;
    tick();
    settle();
    vectors++; if ({bus.busy, bus.owner, bus.mem_req_valid} !== 3'b110) begin miscompares++; $display("FAIL rm_pre busy,owner,valid got=%b exp=110", {bus.busy, bus.owner, bus.mem_req_valid}); end
    rst = 1'b1;
    settle();
    vectors++; if ({bus.busy, bus.owner, bus.mem_req_valid, bus.mem_req_write} !== 4'b0000) begin miscompares++; $display("FAIL rm_ctrl got=%b exp=0000", {bus.busy, bus.owner, bus.mem_req_valid, bus.mem_req_write}); end
    vectors++; if ({bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb} !== 68'h0) begin miscompares++; $display("FAIL rm_fields addr=%h wdata=%h wstrb=%h exp 0", bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb); end
    tick();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1111_2222;
    settle();
    vectors++; if ({bus.if_resp_valid, bus.d_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL rm_stray_resp got=%b exp=00", {bus.if_resp_valid, bus.d_resp_valid}); end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid   = 1'b1;
    bus.if_req_addr    = 32'h0000_0600;
    settle();
    vectors++; if (bus.if_req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_regrant got=%b exp=1", bus.if_req_ready); end
    tick();
    bus.if_req_valid = 1'b0;
    settle();
    vectors++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 32'h0000_0600}) begin miscompares++; $display("FAIL rm_reissue valid=%b addr=%h", bus.mem_req_valid, bus.mem_req_addr); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h3333_4444;
    settle();
    vectors++; if ({bus.if_resp_valid, bus.if_resp_rdata} !== {1'b1, 32'h3333_4444}) begin miscompares++; $display("FAIL rm_resp valid=%b rdata=%h", bus.if_resp_valid, bus.if_resp_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_stray();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0000_0BAD;
    settle();
    vectors++; if ({bus.if_resp_valid, bus.d_resp_valid, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL stray_idle got=%b exp=000", {bus.if_resp_valid, bus.d_resp_valid, bus.busy}); end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.d_req_valid    = 1'b1;
    bus.d_req_addr     = 32'h0000_7000;
    settle();
    vectors++; if (bus.d_req_ready !== 1'b1) begin miscompares++; $display("FAIL stray_grant got=%b exp=1", bus.d_req_ready); end
    tick();
    bus.d_req_valid    = 1'b0;
    bus.mem_resp_valid = 1'b1;
    settle();
    vectors++; if ({bus.if_resp_valid, bus.d_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL stray_issue got=%b exp=00", {bus.if_resp_valid, bus.d_resp_valid}); end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b1;
    settle();
    vectors++; if ({bus.mem_req_valid, bus.busy} !== 2'b11) begin miscompares++; $display("FAIL stray_still_issue got=%b exp=11", {bus.mem_req_valid, bus.busy}); end
    tick();
    bus.mem_req_ready  = 1'b0;
    settle();
    vectors++; if ({bus.mem_req_valid, bus.d_resp_valid} !== 2'b00) begin miscompares++; $display("FAIL stray_wait got=%b exp=00", {bus.mem_req_valid, bus.d_resp_valid}); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0000_600D;
    settle();
    vectors++; if ({bus.d_resp_valid, bus.d_resp_rdata} !== {1'b1, 32'h0000_600D}) begin miscompares++; $display("FAIL stray_final valid=%b rdata=%h", bus.d_resp_valid, bus.d_resp_rdata); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL stray_idle_after got=%b exp=0", bus.busy); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch_only();
    test_data_write();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_stray();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core-side request port of the AXI4-Lite master adapter between two requesters: instruction fetch (read-only) and data load/store.
- One transaction is outstanding at a time.
- Priority goes to data, with a bounded-streak fairness rule so fetch cannot starve.
- The response is routed back to the requester that owns the transaction.

Parameters:
- DATA_MAX_STREAK, 4: maximum consecutive data grants while fetch is waiting; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request pending
- if_req_addr  in  32  fetch address
- if_req_ready  out  1  fetch grant pulse; request fields captured this cycle
- if_resp_valid  out  1  fetch read data valid, one-cycle pulse
- if_resp_rdata  out  32  fetch read data
- d_req_valid  in  1  data request pending
- d_req_write  in  1  1 = write, 0 = read
- d_req_addr  in  32  data address
- d_req_wdata  in  32  write data
- d_req_wstrb  in  4  byte strobes
- d_req_ready  out  1  data grant pulse
- d_resp_valid  out  1  data completion pulse (read data or write ack)
- d_resp_rdata  out  32  data read data
- mem_req_valid  out  1  to adapter request valid
- mem_req_write  out  1  to adapter
- mem_req_addr  out  32  to adapter
- mem_req_wdata  out  32  to adapter
- mem_req_wstrb  out  4  to adapter
- mem_req_ready  in  1  adapter accepts when valid && ready
- mem_resp_valid  in  1  adapter completion pulse
- mem_resp_rdata  in  32  adapter read data
- busy  out  1  high whenever state != IDLE
- owner  out  1  0 = fetch, 1 = data; valid while busy

Behaviour:
Reset:
- Asynchronous on rst=1.
- State = IDLE, streak = 0, owner = 0.
- All captured request registers are 0.
- All valid/ready/busy outputs are 0.
- Reset mid-transaction abandons the transaction; no response is delivered.

States:
- IDLE
  - If either request is valid, select a winner.
  - Pulse that requester's *_req_ready combinationally in the same cycle.
  - Capture addr/write/wdata/wstrb and owner into registers.
  - Next state is ISSUE.
  - Otherwise remain in IDLE.
- ISSUE
  - mem_req_valid=1, driven from the registered fields.
  - Fields stay stable until mem_req_valid && mem_req_ready; then go to WAIT_RESP.
  - No grants are issued.
- WAIT_RESP
  - mem_req_valid=0.
  - On mem_resp_valid, pulse the owner's *_resp_valid in the same cycle and go to IDLE.
  - *_resp_rdata = mem_resp_rdata, combinational pass-through.
  - The non-owner resp_valid stays 0.

Capture rules:
- A fetch grant captures write=0, wstrb=0, wdata=0.

Arbitration (IDLE only):
- Only one valid: grant it.
- Both valid and streak < DATA_MAX_STREAK: grant data, streak += 1.
- Both valid and streak == DATA_MAX_STREAK: grant fetch, streak = 0.
- Any fetch grant, or a data grant with if_req_valid=0: streak = 0.
- The streak counter is $clog2(DATA_MAX_STREAK+1) bits and never exceeds DATA_MAX_STREAK.

Latency and timing:
- Grant at cycle t; mem_req_valid is first high at t+1.
- Response is delivered in the same cycle as mem_resp_valid.
- Next grant is possible at the cycle after the response at the earliest.
- Requesters may hold or drop *_req_valid after their grant. A held valid is treated as a new request.

Stray and simultaneous events:
- mem_resp_valid in IDLE or ISSUE is ignored; no resp pulse is generated.
- A requester valid that rises during ISSUE or WAIT_RESP waits for IDLE.

Test Plan:
1. Fetch only, if_req_addr=0x0000_0100, mem_req_ready=1, resp 2 cycles later with rdata=0xDEAD_BEEF:
   - if_req_ready pulses at t0.
   - mem_req_valid=1, addr=0x100, write=0, wstrb=0 at t1.
   - if_resp_valid=1, rdata=0xDEAD_BEEF at the response cycle; d_resp_valid=0 throughout.
2. Data write, addr=0x2000, wdata=0x1234_5678, wstrb=0xF:
   - mem_* fields match exactly.
   - The write-ack mem_resp_valid yields d_resp_valid=1 and owner=1.
3. Both requesters continuously valid, DATA_MAX_STREAK=4, 12 transactions:
   - Grant order is D,D,D,D,I,D,D,D,D,I,D,D.
   - Never two grants within one transaction.
4. mem_req_ready held 0 for 3 cycles after issue:
   - mem_req_valid and all fields are stable for 4 cycles; busy=1.
   - No *_req_ready pulses although d_req_valid=1.
5. rst asserted in WAIT_RESP, then mem_resp_valid pulsed:
   - All outputs are 0 immediately after rst.
   - The stray response produces no if/d resp_valid.
   - The next request is granted normally.
6. Stray mem_resp_valid in IDLE and ISSUE:
   - No resp pulses.
   - The ISSUE transaction still completes on its proper later response.
